// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared types and default widths for the burst arbiter
// Revision    : 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/burst_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// burst_counter : walks a burst's word addresses (wrapping) and flags the last
// Revision      : 1.0
// ----------------------------------------------------------------------------
module burst_counter #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (load) begin
      r_addr      <= start_addr;
      // a zero length still moves one word
      r_remaining <= (len == '0) ? LEN_W'(1) : len;
    end else if (step) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  assign addr = r_addr;
  assign last = (r_remaining == LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_burst_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_burst_arbiter : round-robin burst arbiter for a shared single-port memory
// Option MEM_ARB_RD_REG_EN registers the read return path.   Revision : 1.0
// ----------------------------------------------------------------------------
module mem_burst_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int LEN_W  = mem_arb_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [LEN_W-1:0]  r_len,
  output logic              r_gnt,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  output logic              r_done,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [LEN_W-1:0]  w_len,
  output logic              w_gnt,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  output logic              w_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wrData,
  input  logic [DATA_W-1:0] mem_rdData
);

  import mem_arb_pkg::*;

  state_t            r_state, w_next_state;
  owner_t            r_last_owner, w_next_owner;
  logic              w_load, w_step, w_last, w_grant_ok;
  logic [ADDR_W-1:0] w_ld_addr, w_cur_addr;
  logic [LEN_W-1:0]  w_ld_len;
  logic              w_rd_valid, w_rd_done;

  burst_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .step       (w_step),
    .start_addr (w_ld_addr),
    .len        (w_ld_len),
    .addr       (w_cur_addr),
    .last       (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_owner <= WRITE;
    end else begin
      r_state      <= w_next_state;
      r_last_owner <= w_next_owner;
    end
  end

  // every output is forced low while reset is held, so a burst cut by reset
  // cannot write its current word
  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_last_owner;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_ld_addr    = r_addr;
    w_ld_len     = r_len;
    r_gnt        = 1'b0;
    w_gnt        = 1'b0;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    mem_address  = '0;
    mem_wr       = 1'b0;
    mem_wrData   = '0;
    w_rd_valid   = 1'b0;
    w_rd_done    = 1'b0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (w_grant_ok) begin
            if (r_req && (!w_req || r_last_owner == WRITE)) begin
              r_gnt        = 1'b1;
              w_load       = 1'b1;
              w_next_state = RD_BURST;
              w_next_owner = READ;
            end else if (w_req) begin
              w_gnt        = 1'b1;
              w_load       = 1'b1;
              w_ld_addr    = w_addr;
              w_ld_len     = w_len;
              w_next_state = WR_BURST;
              w_next_owner = WRITE;
            end
          end
        end
        RD_BURST: begin
          mem_address = w_cur_addr;
          w_rd_valid  = 1'b1;
          w_step      = 1'b1;
          if (w_last) begin
            w_rd_done    = 1'b1;
            w_next_state = IDLE;
          end
        end
        WR_BURST: begin
          mem_address = w_cur_addr;
          mem_wr      = 1'b1;
          mem_wrData  = w_data;
          w_ready     = 1'b1;
          w_step      = 1'b1;
          if (w_last) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RD_REG_EN
  logic              r_rd_valid_q, r_rd_done_q;
  logic [DATA_W-1:0] r_rd_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_valid_q <= 1'b0;
      r_rd_done_q  <= 1'b0;
      r_rd_data_q  <= '0;
    end else begin
      r_rd_valid_q <= w_rd_valid;
      r_rd_done_q  <= w_rd_done;
      r_rd_data_q  <= w_rd_valid ? mem_rdData : '0;
    end
  end

  assign r_valid    = r_rd_valid_q & rst;
  assign r_done     = r_rd_done_q & rst;
  assign r_data     = rst ? r_rd_data_q : '0;
  // hold off the next grant until the trailing read word has left
  assign w_grant_ok = ~r_rd_valid_q;
`else
  assign r_valid    = w_rd_valid;
  assign r_done     = w_rd_done;
  assign r_data     = w_rd_valid ? mem_rdData : '0;
  assign w_grant_ok = 1'b1;
`endif

endmodule
`default_nettype wire

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Shares the single-port 128x32 image memory between two requesters.
- Read port: the filter fetch path. Write port: the result write-back path.
- Grants whole bursts of consecutive words, round-robin between requesters; drives memory address, write enable and write data.
- Sits between the filter datapath/controller and the memory block; the memory has a combinational read and a write on the clock edge.

Parameters:
- ADDR_W, 7, memory word-address width (128 words).
- DATA_W, 32, memory word width (4 packed 8-bit pixels, byte 0 in [31:24]).
- LEN_W, 7, burst-length field width.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- r_req  in  1  read requester wants a burst; held until r_gnt
- r_addr  in  ADDR_W  read burst start word address
- r_len  in  LEN_W  read burst word count; 0 treated as 1
- r_gnt  out  1  one-cycle pulse: read burst accepted
- r_valid  out  1  r_data holds a valid word this cycle
- r_data  out  DATA_W  read word
- r_done  out  1  one-cycle pulse with the last read word
- w_req  in  1  write requester wants a burst; held until w_gnt
- w_addr  in  ADDR_W  write burst start word address
- w_len  in  LEN_W  write burst word count; 0 treated as 1
- w_gnt  out  1  one-cycle pulse: write burst accepted
- w_data  in  DATA_W  current write word
- w_ready  out  1  w_data consumed this cycle; requester advances next cycle
- w_done  out  1  one-cycle pulse with the last written word
- mem_address  out  ADDR_W  memory address
- mem_wr  out  1  memory write enable
- mem_wrData  out  DATA_W  memory write word
- mem_rdData  in  DATA_W  memory combinational read word

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, last_owner=WRITE.
  - Every output 0, including mem_address=0 and mem_wr=0.
  - Reset dominates everything; an in-flight burst is abandoned with no further write and no done pulse.
- States: IDLE, RD_BURST, WR_BURST.
- IDLE:
  - Only r_req set: r_gnt=1 combinationally this cycle; latch cur_addr=r_addr and remaining=max(r_len,1); next state RD_BURST.
  - Only w_req set: same with the w_* inputs, w_gnt=1; next state WR_BURST.
  - Both set: grant the requester that is not last_owner; last_owner updates to the granted side.
  - Neither set: stay IDLE; mem_wr=0.
- RD_BURST, each cycle:
  - mem_address=cur_addr, r_valid=1, r_data=mem_rdData (same-cycle).
  - cur_addr+1 modulo 2^ADDR_W (127 wraps to 0); remaining-1.
  - When remaining==1: r_done=1, next state IDLE.
- WR_BURST, each cycle:
  - mem_address=cur_addr, mem_wr=1, mem_wrData=w_data, w_ready=1.
  - Address and count update, wrap and w_done as in RD_BURST.
- Latency: grant cycle, then first data cycle immediately after. N-word burst occupies N+1 cycles including the grant.
- Requests arriving during a burst are held by the requester; they are evaluated only in IDLE.
- No back-to-back grant without an IDLE cycle.
- r_gnt and w_gnt are never asserted together.

Optional Feature:
- Macro: MEM_ARB_RD_REG_EN.
- Defined:
  - r_data and r_valid are registered, so read data arrives one cycle after its address.
  - r_done is delayed to align with the last word.
  - The arbiter returns to IDLE as before, but a new grant waits until the trailing r_valid has been emitted (one extra cycle after a read burst).
- Undefined: combinational read path as specified above.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, RD_BURST, WR_BURST);
  - the owner enum (READ, WRITE);
  - constants ADDR_W=7, DATA_W=32, LEN_W=7.
- Sub-module burst_counter:
  - loads start address and length;
  - steps address (wrapping) and remaining count;
  - flags the last word.
- The top module holds the FSM and round-robin logic.

Test Plan:
- Reset with rst=0 for 2 cycles, all requests high -> all outputs 0, no grant until rst=1.
- r_req, r_addr=10, r_len=4; memory preloaded with mem[10..13]=A,B,C,D -> r_gnt cycle 0; r_valid cycles 1-4 with data A-D at addresses 10-13; r_done at cycle 4; IDLE at cycle 5.
- w_req, w_addr=126, w_len=3, data X,Y,Z -> mem[126]=X, mem[127]=Y, mem[0]=Z (wrap); w_ready on 3 cycles; w_done on the third.
- r_req and w_req together from reset -> read granted first; after it completes, write granted next. Repeat with both held -> grants strictly alternate.
- rst=0 during the 2nd word of a 5-word write -> only the first word is written; no w_done; mem_wr=0 from the reset edge.
- r_len=0 -> exactly one word read with r_done. With MEM_ARB_RD_REG_EN defined: r_valid one cycle later than address, r_data equals the registered word.
